// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier scheduler and its arbiter.
package mult_pkg;

  localparam int WIDTH_DEF       = 32;
  localparam int NREQ_DEF        = 4;
  localparam int MUL_LATENCY_DEF = 34;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    WAIT,
    RESP
  } state_e;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o
);

  int            j;
  logic [IW-1:0] j_idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    j         = 0;
    j_idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      j_idx = IW'(j);
      if (req_i[j_idx]) begin
        gnt_o        = '0;
        gnt_o[j_idx] = 1'b1;
        gnt_idx_o    = j_idx;
      end
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one external sequential multiplier among NREQ requesters: arbitrate,
// sequence the multiplier pins, wait the fixed latency, return the product.
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int NREQ        = NREQ_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic signed [2*WIDTH-1:0] rsp_data,
  output logic                      busy,
  output logic                      mul_rst,
  output logic                      mul_load,
  output logic signed [WIDTH-1:0]   mul_a,
  output logic signed [WIDTH-1:0]   mul_b,
  input  logic signed [2*WIDTH-1:0] mul_out
);

  localparam int            IW       = idx_w(NREQ);
  localparam int            CW       = $clog2(MUL_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  state_e                    state_q, state_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]             gnt_idx_q, gnt_idx_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic signed [WIDTH-1:0]   a_q, b_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            req_hs, rsp_hs, cnt_done;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign req_hs   = (state_q == IDLE) && (|req_valid);
  assign rsp_hs   = (state_q == RESP) && rsp_ready[gnt_idx_q];
  assign cnt_done = (cnt_q == CNT_LAST);
  assign rsp_data = rsp_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Operand holding registers; only observable through the gated mul_a/mul_b.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      a_q <= req_a[arb_idx*WIDTH +: WIDTH];
      b_q <= req_b[arb_idx*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d   = CLEAR;
          gnt_idx_d = arb_idx;
          rr_ptr_d  = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
        end
      end
      CLEAR: state_d = LOAD;
      LOAD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_done) begin
          state_d    = RESP;
          cnt_d      = '0;
          rsp_data_d = mul_out;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mul_rst also follows the block reset so the multiplier is held while rst is low.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_rst   = ~rst;
    mul_load  = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE:  if (rst) req_ready = arb_gnt;
      CLEAR: mul_rst = 1'b1;
      LOAD: begin
        mul_load = 1'b1;
        mul_a    = a_q;
        mul_b    = b_q;
      end
      WAIT: begin
        mul_a = a_q;
        mul_b = b_q;
      end
      RESP:    rsp_valid[gnt_idx_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a behavioural fixed-latency multiplier.
module tb_mult_scheduler;
  import mult_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int ML = 34;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_ready;
  logic [N*W-1:0]        req_a = '0;
  logic [N*W-1:0]        req_b = '0;
  logic [N-1:0]          rsp_valid;
  logic [N-1:0]          rsp_ready = '0;
  logic signed [2*W-1:0] rsp_data;
  logic                  busy, mul_rst, mul_load;
  logic signed [W-1:0]   mul_a, mul_b;
  logic signed [2*W-1:0] mul_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int                    idx;
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic signed [2*W-1:0] p;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mult_scheduler #(
    .WIDTH       (W),
    .NREQ        (N),
    .MUL_LATENCY (ML)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mul_rst   (mul_rst),
    .mul_load  (mul_load),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out)
  );

  // Multiplier model: product valid exactly ML cycles after the load cycle, garbage before.
  logic signed [2*W-1:0] m_prod = '0;
  int                    m_cnt  = 0;

  always @(posedge clk) begin
    if (mul_rst) m_cnt <= 0;
    else if (mul_load) begin
      m_prod <= 64'($signed(mul_a)) * 64'($signed(mul_b));
      m_cnt  <= 1;
    end else if (m_cnt != 0 && m_cnt < ML) m_cnt <= m_cnt + 1;
  end

  assign mul_out = (m_cnt == ML) ? m_prod : 64'sh5A5A_5A5A_5A5A_5A5A;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    exp_t e;
    e.idx = i;
    e.a   = a;
    e.b   = b;
    e.p   = 64'(a) * 64'(b);
    sb.push_back(e);
  endtask

  // Follows one transaction from grant to completed response against the scoreboard head.
  task automatic serve_one(input bit keep_valid, input int bp, input string tag);
    exp_t         e;
    logic [N-1:0] oh;
    int           k;
    int           bad;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 128'(sb.size()), 128'(1));
      return;
    end
    e      = sb.pop_front();
    oh     = '0;
    oh[e.idx] = 1'b1;
    k = 0;
    while (req_ready == '0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_grant"}, 128'(req_ready), 128'(oh));
    if (req_ready == '0) return;
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid[e.idx] = 1'b0;
    @(negedge clk);
    chk({tag, "_clear"}, 128'({busy, mul_rst, mul_load}), 128'(3'b110));
    @(negedge clk);
    chk({tag, "_load"}, 128'({mul_rst, mul_load, mul_a, mul_b}), 128'({1'b0, 1'b1, e.a, e.b}));
    bad = 0;
    for (int c = 0; c < ML; c++) begin
      @(negedge clk);
      if (mul_rst !== 1'b0 || mul_load !== 1'b0 || mul_a !== e.a || mul_b !== e.b ||
          rsp_valid !== '0 || req_ready !== '0 || busy !== 1'b1) bad++;
    end
    chk({tag, "_wait"}, 128'(bad), 128'(0));
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(oh));
    chk({tag, "_rsp_data"}, 128'(rsp_data), 128'(e.p));
    if (bp > 0) begin
      bad = 0;
      for (int c = 0; c < bp; c++) begin
        @(negedge clk);
        if (rsp_valid !== oh || rsp_data !== e.p || req_ready !== '0 || busy !== 1'b1) bad++;
      end
      chk({tag, "_hold"}, 128'(bad), 128'(0));
      rsp_ready[e.idx] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, 128'({rsp_valid, busy}), 128'(0));
    chk({tag, "_data_held"}, 128'(rsp_data), 128'(e.p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset state, with a request present to show req_ready is held low.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rst_ctrl", 128'({req_ready, rsp_valid, busy, mul_rst, mul_load}),
        128'({4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0}));
    chk("rst_data", 128'({mul_a, mul_b, rsp_data}), 128'(0));
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 128'({mul_rst, busy, req_ready}), 128'(0));
    rsp_ready = '1;

    // Single request from requester 0.
    @(posedge clk); #1;
    drive_req(0, 12, -32);
    push_exp(0, 12, -32);
    serve_one(1'b0, 0, "single");

    // Backpressure on requester 3; other rsp_ready bits high must be ignored.
    rsp_ready = 4'b0111;
    @(posedge clk); #1;
    drive_req(3, 13, 20);
    push_exp(3, 13, 20);
    serve_one(1'b0, 10, "bp");
    rsp_ready = '1;

    // All four requesters at once, pointer back at 0.
    @(posedge clk); #1;
    drive_req(0, 5, 15);
    drive_req(1, -51, -4);
    drive_req(2, -25, -60);
    drive_req(3, 0, 1234);
    push_exp(0, 5, 15);
    push_exp(1, -51, -4);
    push_exp(2, -25, -60);
    push_exp(3, 0, 1234);
    serve_one(1'b0, 0, "all0");
    serve_one(1'b0, 0, "all1");
    serve_one(1'b0, 0, "all2");
    serve_one(1'b0, 0, "all3");

    // Fairness between two continuously valid requesters.
    @(posedge clk); #1;
    drive_req(1, 1, 12);
    drive_req(3, -12, 72);
    push_exp(1, 1, 12);
    push_exp(3, -12, 72);
    push_exp(1, 1, 12);
    push_exp(3, -12, 72);
    serve_one(1'b1, 0, "fair0");
    serve_one(1'b1, 0, "fair1");
    serve_one(1'b0, 0, "fair2");
    serve_one(1'b0, 0, "fair3");

    // Asynchronous reset in the middle of WAIT.
    @(posedge clk); #1;
    drive_req(0, 7, 9);
    #1;
    chk("arst_grant", 128'(req_ready), 128'(4'b0001));
    repeat (12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ctrl", 128'({busy, rsp_valid, req_ready, mul_rst, mul_load}),
        128'({1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0}));
    chk("arst_ops", 128'({mul_a, mul_b, rsp_data}), 128'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    chk("arst_no_rsp", 128'(bad), 128'(0));

    // After reset the pointer is 0 again, so requester 0 wins over 1.
    @(posedge clk); #1;
    drive_req(0, 12, 5);
    drive_req(1, 3, -7);
    push_exp(0, 12, 5);
    push_exp(1, 3, -7);
    serve_one(1'b0, 0, "post0");
    serve_one(1'b0, 0, "post1");

    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Sequencer and round-robin arbiter that shares one 32-bit signed sequential Booth multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's reset/load/operand pins in the required order. It waits a fixed latency, captures the 64-bit product and returns it to the originating requester over a per-requester valid/ready response channel. It sits between client blocks and the multiplier instance; the multiplier itself is external to this block.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- NREQ, 4, number of requesters (≥2)
- MUL_LATENCY, 34, cycles from the mul_load cycle to a valid mul_out (≥1)
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  request accepted; at most one bit high
- req_a  in  NREQ*WIDTH  signed operand A; slice i belongs to requester i
- req_b  in  NREQ*WIDTH  signed operand B; slice i belongs to requester i
- rsp_valid  out  NREQ  product available, one-hot or zero
- rsp_ready  in  NREQ  requester takes the product
- rsp_data  out  2*WIDTH  signed product, shared by all requesters
- busy  out  1  high in every state except IDLE
- mul_rst  out  1  active-high reset to the multiplier
- mul_load  out  1  operand-load strobe to the multiplier
- mul_a, mul_b  out  WIDTH  operands to the multiplier
- mul_out  in  2*WIDTH  multiplier product

## Operation
- FSM states: IDLE, CLEAR, LOAD, WAIT, RESP.
- IDLE:
  - Grant = first requester with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready[grant] = 1 combinationally.
  - On the handshake: latch req_a/req_b slices and the grant index; rr_ptr ← grant+1 mod NREQ; go to CLEAR.
  - No valid request: stay in IDLE.
- CLEAR: mul_rst = 1 for one cycle → LOAD.
- LOAD:
  - mul_load = 1 for one cycle → WAIT.
  - mul_a/mul_b carry the latched operands in LOAD and hold them through WAIT.
- WAIT:
  - Counter counts MUL_LATENCY cycles.
  - On the last count: capture mul_out into rsp_data → RESP.
- RESP:
  - rsp_valid[grant] = 1 and rsp_data stable until rsp_ready[grant] = 1, then → IDLE.
  - rsp_ready of other requesters is ignored.
  - No new request is accepted in RESP.
- Requests from non-granted requesters wait; the block never drops them.
  - Round-robin guarantees each continuously-valid requester is served within NREQ transactions.
- rsp_data is a register; it holds the last product until the next capture.
- Signedness: the product is passed through unmodified; no truncation or saturation.
- Reset (async, any state, including mid-transaction):
  - State → IDLE; rr_ptr → 0; counter → 0.
  - The pending transaction is discarded; no response is issued.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 0
  - mul_load = 0, mul_a = 0, mul_b = 0
  - mul_rst = 1 while rst is low, 0 in IDLE after release

## Timing
- Request handshake in cycle T, relative to that handshake:
  - CLEAR at T+1, LOAD at T+2
  - WAIT spans T+3 … T+2+MUL_LATENCY
  - rsp_valid rises at T+3+MUL_LATENCY; with the default latency, T+37
- Minimum request-to-request spacing is MUL_LATENCY+4 cycles.
  - A response accepted in cycle R lets the next request handshake occur at R+1.
- req_ready depends combinationally on req_valid and state.
- All other outputs are registered or decoded from state only.
- Simultaneous requests in IDLE: exactly one grant, chosen by rr_ptr.
- rsp_ready may be held high early; the handshake completes in the first RESP cycle.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, WAIT, RESP)
  - default WIDTH and MUL_LATENCY constants
  - a clog2-based index width for NREQ
- One sub-module, rr_arbiter:
  - inputs: request vector, pointer
  - outputs: one-hot grant and grant index
  - purely combinational
- The pointer register lives in mult_scheduler.

## Test plan
- Single request: requester 0 sends 12 × -32 → req_ready[0] at T, rsp_valid[0] at T+37, rsp_data = -384; other rsp_valid bits stay 0.
- All four requesters valid at once, operands (5,15), (-51,-4), (-25,-60), (0,1234) → served in order 0,1,2,3; products 75, 204, 1500, 0; each issued exactly once.
- Fairness: requester 1 continuously valid (1 × 12) and requester 3 continuously valid (-12 × 72) → grants alternate 1,3,1,3; products 12 and -864.
- Backpressure: 13 × 20 with rsp_ready held low 10 cycles past rsp_valid → rsp_valid and rsp_data = 260 stable throughout; busy = 1; no new req_ready until after the handshake.
- Async reset asserted mid-WAIT → busy, rsp_valid and req_ready drop immediately; mul_rst = 1; no response issued. After release, a 12 × 5 request completes with product 60 at T+37.
- Pin sequencing check: mul_rst high exactly one cycle, then mul_load high exactly one cycle; mul_a/mul_b equal the latched operands from LOAD until RESP.
